// File: rtl/rs_chien_root_collector_pkg.sv
// GF(2^8) constants, shared types and the GF multiplier used by the Chien-search stage.
package rs_chien_root_collector_pkg;

  localparam int unsigned SYMB_WIDTH     = 8;
  localparam int unsigned T_LEN          = 8;
  localparam int unsigned N_LEN          = 255;
  localparam int unsigned POS_WIDTH      = $clog2(N_LEN);
  localparam int unsigned DEG_WIDTH      = $clog2(T_LEN + 1);
  localparam int unsigned CNT_WIDTH      = $clog2(N_LEN + 1);
  localparam int unsigned IDX_WIDTH      = $clog2(T_LEN);
  localparam int unsigned FF_STEP__CHIEN = 2;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [T_LEN:0]       poly_t;
  typedef logic [POS_WIDTH-1:0]  pos_t;
  typedef pos_t [T_LEN-1:0]      pos_arr_t;

  // Field polynomial x^8+x^4+x^3+x^2+1 (low byte), alpha = 2, alpha^-1 = alpha^254.
  localparam symb_t GF_PRIM   = 8'h1D;
  localparam symb_t ALPHA_INV = 8'h8E;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} chien_state_t;

  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[SYMB_WIDTH-1] ? ((aa << 1) ^ GF_PRIM) : (aa << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_chien_root_collector_if.sv
// Locator-in / position-list-out handshake bundle of the Chien-search stage.
interface rs_chien_root_collector_if;
  import rs_chien_root_collector_pkg::*;

  logic                 loc_vld_i;
  logic                 loc_rdy_o;
  poly_t                loc_poly_i;
  logic [DEG_WIDTH-1:0] loc_deg_i;
  logic                 res_vld_o;
  logic                 res_rdy_i;
  pos_arr_t             err_pos_o;
  logic [DEG_WIDTH-1:0] err_num_o;
  logic                 dec_fail_o;

  modport slave (
    input  loc_vld_i, loc_poly_i, loc_deg_i, res_rdy_i,
    output loc_rdy_o, res_vld_o, err_pos_o, err_num_o, dec_fail_o
  );

  modport master (
    output loc_vld_i, loc_poly_i, loc_deg_i, res_rdy_i,
    input  loc_rdy_o, res_vld_o, err_pos_o, err_num_o, dec_fail_o
  );

endinterface

// File: rtl/rs_chien_root_collector_gf_poly_eval.sv
// Pipelined Horner evaluator: register stage after every FF_STEP Horner steps, plus output register.
module rs_chien_root_collector_gf_poly_eval import rs_chien_root_collector_pkg::*; #(
  parameter int unsigned FF_STEP = FF_STEP__CHIEN
) (
  input  logic  clk,
  input  logic  rst_n,
  input  poly_t i_poly,
  input  symb_t i_symb,
  input  logic  i_vld,
  output symb_t o_value,
  output logic  o_vld
);

  localparam int unsigned STEP_DIV = (FF_STEP == 0) ? 1 : FF_STEP;

  symb_t w_acc [T_LEN+1];
  symb_t w_x   [T_LEN];
  logic  w_v   [T_LEN+1];

  assign w_acc[0] = i_poly[T_LEN];
  assign w_x[0]   = i_symb;
  assign w_v[0]   = i_vld;

  // The evaluation point travels with its partial sum; coefficients are held constant upstream.
  for (genvar s = 1; s <= T_LEN; s++) begin : g_step
    symb_t w_sum;
    assign w_sum = gf_mult(w_acc[s-1], w_x[s-1]) ^ i_poly[T_LEN-s];

    if (FF_STEP != 0 && (s % STEP_DIV) == 0) begin : g_reg
      symb_t r_acc;
      logic  r_v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
          r_v   <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_v   <= w_v[s-1];
        end
      end
      assign w_acc[s] = r_acc;
      assign w_v[s]   = r_v;
      if (s < T_LEN) begin : g_x
        symb_t r_x;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_x <= '0;
          else        r_x <= w_x[s-1];
        end
        assign w_x[s] = r_x;
      end
    end else begin : g_comb
      assign w_acc[s] = w_sum;
      assign w_v[s]   = w_v[s-1];
      if (s < T_LEN) begin : g_x
        assign w_x[s] = w_x[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_value <= '0;
      o_vld   <= 1'b0;
    end else begin
      o_value <= w_acc[T_LEN];
      o_vld   <= w_v[T_LEN];
    end
  end

endmodule

// File: rtl/rs_chien_root_collector.sv
// RS Chien search: evaluates the BM locator at alpha^-i, collects root positions for Forney.
// Optional RS_CHIEN_EARLY_STOP_EN stops issuing once loc_deg roots have returned.
module rs_chien_root_collector import rs_chien_root_collector_pkg::*; (
  input logic                      aclk,
  input logic                      aresetn,
  rs_chien_root_collector_if.slave bus
);

  chien_state_t         r_state, w_next;
  poly_t                r_poly;
  logic [DEG_WIDTH-1:0] r_deg;
  symb_t                r_symb;
  logic [CNT_WIDTH-1:0] r_iss_cnt;
  logic [CNT_WIDTH-1:0] r_ret_cnt;
  logic [DEG_WIDTH-1:0] r_root_cnt;
  logic                 r_fail;
  logic                 r_dec_fail;
  pos_arr_t             r_pos;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_ev_vld;
  symb_t                w_ev_value;
  logic [CNT_WIDTH-1:0] w_drain_target;

`ifdef RS_CHIEN_EARLY_STOP_EN
  assign w_drain_target = r_iss_cnt;
`else
  assign w_drain_target = CNT_WIDTH'(N_LEN);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.loc_vld_i) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: begin
`ifdef RS_CHIEN_EARLY_STOP_EN
        if (r_deg != '0 && r_root_cnt == r_deg) begin
          w_next = DRAIN;
        end else begin
          w_issue = 1'b1;
          if (r_iss_cnt == CNT_WIDTH'(N_LEN - 1)) w_next = DRAIN;
        end
`else
        w_issue = 1'b1;
        if (r_iss_cnt == CNT_WIDTH'(N_LEN - 1)) w_next = DRAIN;
`endif
      end
      DRAIN: begin
        if (r_ret_cnt == w_drain_target) w_next = DONE;
      end
      DONE: begin
        if (bus.res_rdy_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Results are attributed to positions purely by return order, independent of evaluator latency.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_poly     <= '0;
      r_deg      <= '0;
      r_symb     <= '0;
      r_iss_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_root_cnt <= '0;
      r_fail     <= 1'b0;
      r_dec_fail <= 1'b0;
      r_pos      <= '0;
    end else begin
      if (w_accept) begin
        r_poly     <= bus.loc_poly_i;
        r_deg      <= bus.loc_deg_i;
        r_symb     <= symb_t'(1);
        r_iss_cnt  <= '0;
        r_ret_cnt  <= '0;
        r_root_cnt <= '0;
        r_fail     <= 1'b0;
        r_dec_fail <= 1'b0;
        r_pos      <= '0;
      end else begin
        if (w_issue) begin
          r_symb    <= gf_mult(r_symb, ALPHA_INV);
          r_iss_cnt <= r_iss_cnt + 1'b1;
        end
        if (w_ev_vld) begin
          r_ret_cnt <= r_ret_cnt + 1'b1;
          if (w_ev_value == '0) begin
            if (r_root_cnt < DEG_WIDTH'(T_LEN)) begin
              r_pos[r_root_cnt[IDX_WIDTH-1:0]] <= POS_WIDTH'(r_ret_cnt);
              r_root_cnt <= r_root_cnt + 1'b1;
            end else begin
              r_fail <= 1'b1;
            end
          end
        end
        if (r_state == DRAIN && w_next == DONE) begin
          r_dec_fail <= r_fail | (r_root_cnt != r_deg);
        end
      end
    end
  end

  rs_chien_root_collector_gf_poly_eval #(
    .FF_STEP (FF_STEP__CHIEN)
  ) u_gf_poly_eval (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_poly  (r_poly),
    .i_symb  (r_symb),
    .i_vld   (w_issue),
    .o_value (w_ev_value),
    .o_vld   (w_ev_vld)
  );

  assign bus.loc_rdy_o  = (r_state == IDLE);
  assign bus.res_vld_o  = (r_state == DONE);
  assign bus.err_pos_o  = r_pos;
  assign bus.err_num_o  = r_root_cnt;
  assign bus.dec_fail_o = r_dec_fail;

endmodule

// File: tb/tb_rs_chien_root_collector.sv
// Directed bench for rs_chien_root_collector: locators built from known error positions.
module tb_rs_chien_root_collector;
  import rs_chien_root_collector_pkg::*;

  typedef logic [DEG_WIDTH-1:0] deg_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   acc_cyc      = 0;

  rs_chien_root_collector_if bus();

  rs_chien_root_collector dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Carry-less product followed by reduction modulo 0x11D.
  function automatic symb_t m_mul(input symb_t a, input symb_t b);
    logic [15:0] prod;
    logic [15:0] prim;
    prod = '0;
    prim = 16'h011D;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (prim << (i - 8));
    return prod[7:0];
  endfunction

  function automatic symb_t m_pow(input int e);
    symb_t r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = m_mul(r, 8'h02);
    return r;
  endfunction

  // Product of (1 + alpha^e x) over up to two error positions.
  function automatic poly_t m_loc(input int e0, input int e1, input int n);
    poly_t p;
    symb_t a;
    p    = '0;
    p[0] = 8'h01;
    for (int k = 0; k < n; k++) begin
      a = m_pow((k == 0) ? e0 : e1);
      for (int j = T_LEN; j >= 1; j--) p[j] = p[j] ^ m_mul(a, p[j-1]);
    end
    return p;
  endfunction

  function automatic int m_roots(input poly_t p);
    int    n;
    symb_t x, xp, sum, ainv;
    n    = 0;
    ainv = m_pow(254);
    x    = 8'h01;
    for (int i = 0; i < 255; i++) begin
      sum = '0;
      xp  = 8'h01;
      for (int j = 0; j <= T_LEN; j++) begin
        sum = sum ^ m_mul(p[j], xp);
        xp  = m_mul(xp, x);
      end
      if (sum == '0) n++;
      x = m_mul(x, ainv);
    end
    return n;
  endfunction

  task automatic send_word(input poly_t p, input deg_t d);
    int n;
    n = 0;
    @(negedge aclk);
    bus.loc_poly_i = p;
    bus.loc_deg_i  = d;
    bus.loc_vld_i  = 1'b1;
    while (bus.loc_rdy_o !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    tests_run++;
    if (bus.loc_rdy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept: loc_rdy_o=%b required 1", bus.loc_rdy_o);
    end
    @(posedge aclk);
    #1;
    acc_cyc       = cyc;
    bus.loc_vld_i = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (bus.res_vld_o !== 1'b1 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    lat = cyc - acc_cyc;
    tests_run++;
    if (bus.res_vld_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL res_timeout: res_vld_o=%b required 1 within 2000 cycles", bus.res_vld_o);
    end
  endtask

  task automatic ack();
    @(negedge aclk);
    bus.res_rdy_i = 1'b1;
    @(negedge aclk);
    bus.res_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.loc_rdy_o, bus.res_vld_o, bus.err_num_o, bus.dec_fail_o} !== {1'b1, 1'b0, deg_t'(0), 1'b0}
        || bus.err_pos_o !== pos_arr_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b vld=%b num=%0d fail=%b pos=%h required rdy=1 vld=0 num=0 fail=0 pos=0",
               bus.loc_rdy_o, bus.res_vld_o, bus.err_num_o, bus.dec_fail_o, bus.err_pos_o);
    end
  endtask

  task automatic test_deg0();
    int lat;
    send_word(m_loc(0, 0, 0), deg_t'(0));
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(0) || bus.dec_fail_o !== 1'b0 || bus.err_pos_o !== pos_arr_t'(0)) begin
      tests_failed++;
      $display("FAIL deg0: num=%0d fail=%b pos=%h required num=0 fail=0 pos=0",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o);
    end
    tests_run++;
    if (lat < N_LEN + 2 || lat > N_LEN + T_LEN + 2) begin
      tests_failed++;
      $display("FAIL deg0_latency: %0d cycles required %0d..%0d", lat, N_LEN + 2, N_LEN + T_LEN + 2);
    end
    ack();
  endtask

  task automatic test_single7();
    int       lat;
    pos_arr_t exp;
    exp    = '0;
    exp[0] = pos_t'(7);
    send_word(m_loc(7, 0, 1), deg_t'(1));
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(1) || bus.err_pos_o !== exp || bus.dec_fail_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single7: num=%0d fail=%b pos=%h required num=1 fail=0 pos=%h",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o, exp);
    end
    ack();
  endtask

  task automatic test_boundary_hold();
    int       lat;
    pos_arr_t exp;
    exp    = '0;
    exp[0] = pos_t'(0);
    exp[1] = pos_t'(254);
    bus.res_rdy_i = 1'b0;
    send_word(m_loc(0, 254, 2), deg_t'(2));
    wait_result(lat);
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (bus.res_vld_o !== 1'b1 || bus.err_num_o !== deg_t'(2) || bus.err_pos_o !== exp
          || bus.dec_fail_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL boundary_hold[%0d]: vld=%b num=%0d fail=%b pos=%h required vld=1 num=2 fail=0 pos=%h",
                 k, bus.res_vld_o, bus.err_num_o, bus.dec_fail_o, bus.err_pos_o, exp);
      end
      @(negedge aclk);
    end
    ack();
    tests_run++;
    if (bus.loc_rdy_o !== 1'b1 || bus.res_vld_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_ack: rdy=%b vld=%b required rdy=1 vld=0", bus.loc_rdy_o, bus.res_vld_o);
    end
  endtask

  task automatic test_irreducible();
    int    lat;
    poly_t p;
    bit    found;
    found = 1'b0;
    for (int c = 2; c < 256 && !found; c++) begin
      p    = '0;
      p[0] = 8'h01;
      p[1] = 8'h01;
      p[2] = symb_t'(c);
      if (m_roots(p) == 0) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL irreducible_search: no rootless 1+x+cx^2 found required one");
    end
    send_word(p, deg_t'(2));
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(0) || bus.dec_fail_o !== 1'b1 || bus.err_pos_o !== pos_arr_t'(0)) begin
      tests_failed++;
      $display("FAIL irreducible: num=%0d fail=%b pos=%h required num=0 fail=1 pos=0",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o);
    end
    ack();
  endtask

  task automatic test_deg_mismatch();
    int       lat;
    pos_arr_t exp;
    exp    = '0;
    exp[0] = pos_t'(7);
    send_word(m_loc(7, 0, 1), deg_t'(2));
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(1) || bus.err_pos_o !== exp || bus.dec_fail_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL deg_mismatch: num=%0d fail=%b pos=%h required num=1 fail=1 pos=%h",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o, exp);
    end
    ack();
  endtask

  task automatic test_vld_during_issue();
    int       lat;
    pos_arr_t exp;
    exp    = '0;
    exp[0] = pos_t'(7);
    send_word(m_loc(7, 0, 1), deg_t'(1));
    repeat (5) @(negedge aclk);
    tests_run++;
    if (bus.loc_rdy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdy_in_issue: loc_rdy_o=%b required 0", bus.loc_rdy_o);
    end
    bus.loc_poly_i = m_loc(100, 0, 1);
    bus.loc_vld_i  = 1'b1;
    repeat (3) @(negedge aclk);
    bus.loc_vld_i  = 1'b0;
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(1) || bus.err_pos_o !== exp || bus.dec_fail_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL vld_ignored: num=%0d fail=%b pos=%h required num=1 fail=0 pos=%h",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o, exp);
    end
    ack();
    repeat (3) @(negedge aclk);
    tests_run++;
    if (bus.res_vld_o !== 1'b0 || bus.loc_rdy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_queue: vld=%b rdy=%b required vld=0 rdy=1", bus.res_vld_o, bus.loc_rdy_o);
    end
  endtask

  task automatic test_reset_mid();
    int       lat;
    pos_arr_t exp;
    exp    = '0;
    exp[0] = pos_t'(3);
    send_word(m_loc(0, 254, 2), deg_t'(2));
    repeat (40) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    tests_run++;
    if ({bus.loc_rdy_o, bus.res_vld_o, bus.err_num_o, bus.dec_fail_o} !== {1'b1, 1'b0, deg_t'(0), 1'b0}
        || bus.err_pos_o !== pos_arr_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_mid: rdy=%b vld=%b num=%0d fail=%b pos=%h required rdy=1 vld=0 num=0 fail=0 pos=0",
               bus.loc_rdy_o, bus.res_vld_o, bus.err_num_o, bus.dec_fail_o, bus.err_pos_o);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    send_word(m_loc(3, 0, 1), deg_t'(1));
    wait_result(lat);
    tests_run++;
    if (bus.err_num_o !== deg_t'(1) || bus.err_pos_o !== exp || bus.dec_fail_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_word: num=%0d fail=%b pos=%h required num=1 fail=0 pos=%h",
               bus.err_num_o, bus.dec_fail_o, bus.err_pos_o, exp);
    end
    tests_run++;
`ifdef RS_CHIEN_EARLY_STOP_EN
    if (lat >= 20 + T_LEN + 1) begin
      tests_failed++;
      $display("FAIL early_stop_latency: %0d cycles required < %0d", lat, 20 + T_LEN + 1);
    end
`else
    if (lat < N_LEN + 2 || lat > N_LEN + T_LEN + 2) begin
      tests_failed++;
      $display("FAIL full_latency: %0d cycles required %0d..%0d", lat, N_LEN + 2, N_LEN + T_LEN + 2);
    end
`endif
    ack();
  endtask

  initial begin
    bus.loc_vld_i  = 1'b0;
    bus.loc_poly_i = '0;
    bus.loc_deg_i  = '0;
    bus.res_rdy_i  = 1'b0;
    aresetn        = 1'b0;
    repeat (3) @(negedge aclk);
    test_reset();
    aresetn = 1'b1;
    test_deg0();
    test_single7();
    test_boundary_hold();
    test_irreducible();
    test_deg_mismatch();
    test_vld_during_issue();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
